// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, lane
// selection and lane rotation used by the read/write datapath.
package mem_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // One-hot byte enable for a little-endian lane (lane 0 = bits [7:0]).
    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        lane_sel = 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] rotr_lanes(input logic [31:0] word, input logic [1:0] lanes);
        case (lanes)
            2'd0:    rotr_lanes = word;
            2'd1:    rotr_lanes = {word[7:0],  word[31:8]};
            2'd2:    rotr_lanes = {word[15:0], word[31:16]};
            default: rotr_lanes = {word[23:0], word[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/memory_array.sv
// Word-wide RAM with per-byte write enables: synchronous write, combinational
// read, contents deliberately left unreset.
module memory_array #(
    parameter int MEM_WORDS = 1024,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we[l]) begin
                mem[addr][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_responder.sv
// Bus slave: accepts one request, waits WAIT_STATES cycles, performs a word or
// byte access on the internal RAM and returns a one-cycle response.
module memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_abort
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t                state;
    state_t                next_state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic                  byte_q;
    logic [31:0]           wdata_q;
    logic                  accept;
    logic                  access;
    logic                  in_range;
    logic [1:0]            lane;
    logic [3:0]            ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [31:0]           rotated;
    logic [31:0]           read_data;

    assign accept   = (state == IDLE) && req_valid;
    assign access   = (state == WAIT) && (wait_cnt == '0);
    assign lane     = addr_q[1:0];
    // Any set bit above the RAM index means the word lies past the array.
    assign in_range = (addr_q[ADDR_WIDTH-1:AW+2] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            wdata_q  <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_W'(WAIT_STATES);
            addr_q   <= req_addr;
            write_q  <= req_write;
            byte_q   <= req_byte;
            wdata_q  <= req_wdata;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_comb begin
        ram_we = 4'b0000;
        if (access && write_q && in_range) begin
            ram_we = byte_q ? lane_sel(lane) : 4'b1111;
        end
    end

    assign ram_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    assign rotated   = rotr_lanes(ram_rdata, lane);
    assign read_data = byte_q ? {24'h0, rotated[7:0]} : rotated;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_abort <= 1'b0;
        end else if (access) begin
            resp_rdata <= (write_q || !in_range) ? 32'h0 : read_data;
            resp_abort <= !in_range;
        end
    end

    memory_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
